// File: rtl/aes_pkg.sv
// Shared AES constants and byte/word transforms used by the iterative
// AES-256 encryption core and its key-schedule step.
package aes_pkg;

   // Forward S-box, indexed by input byte value.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constants for AES-256; entry 0 is unused so the table is
   // indexed directly by (round / 2) for the even key-schedule rounds.
   localparam logic [7:0] RCON [8] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[127 - 8*i -: 8] = SBOX[s[127 - 8*i -: 8]];
      end
      return r;
   endfunction

   // Byte index is row + 4*col; row n rotates left by n columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-256 key schedule: derives round key r from the two
// preceding round keys. Purely combinational.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_prev2,
   input  logic [127:0] rk_prev1,
   input  logic [3:0]   round,
   output logic [127:0] rk_next
);

   logic [31:0] t;
   logic [31:0] w0, w1, w2, w3;

   // Even rounds rotate and add Rcon; odd rounds only substitute.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      t = rk_prev1[31:0];
      if (round[0]) begin
         t = sub_word(rk_prev1[31:0]);
      end else begin
         t = sub_word(rot_word(rk_prev1[31:0])) ^ {RCON[round[3:1]], 24'h0};
      end
   end

   assign w0 = rk_prev2[127:96] ^ t;
   assign w1 = rk_prev2[95:64]  ^ w0;
   assign w2 = rk_prev2[63:32]  ^ w1;
   assign w3 = rk_prev2[31:0]   ^ w2;

   assign rk_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes256_encryption.sv
// Iterative AES-256 encryption core. One round per clock, restarting
// whenever plaintext or key changes; exposes ciphertext and all 15 round keys.
module aes256_encryption
   import aes_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [127:0]    plaintext,
   input  logic [255:0]    initial_key,
   output logic [127:0]    ciphertext,
   output logic [1919:0]   key_chain
);

   logic [127:0] pt_q;
   logic [255:0] key_q;
   logic [127:0] state_q;
   logic [127:0] rk_q [15];
   logic [3:0]   round_q;
   logic         busy_q;
   logic         restart_q;

   logic         capture;
   logic [3:0]   prev1_idx;
   logic [3:0]   prev2_idx;
   logic [127:0] rk_next;
   logic [127:0] round_key;
   logic [127:0] sub_shift;
   logic [127:0] round_out;

   // Any input change (or the pending post-reset restart) starts a new block.
   assign capture = restart_q || (plaintext != pt_q) || (initial_key != key_q);

   assign prev1_idx = round_q - 4'd1;
   assign prev2_idx = round_q - 4'd2;

   aes_key_step u_key_step (
      .rk_prev2 (rk_q[prev2_idx]),
      .rk_prev1 (rk_q[prev1_idx]),
      .round    (round_q),
      .rk_next  (rk_next)
   );

   // Round 1 uses the key loaded at capture; later rounds use the key
   // being generated on this same edge.
   assign round_key = (round_q == 4'd1) ? rk_q[1] : rk_next;
   assign sub_shift = shift_rows(sub_bytes(state_q));
   assign round_out = (round_q == 4'd14) ? (sub_shift ^ round_key)
                                         : (mix_columns(sub_shift) ^ round_key);

   // Capture, then iterate rounds 1..14; idle once the final round is stored.
   always_ff @(posedge clk_i or negedge reset_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_i) begin
         pt_q      <= '0;
         key_q     <= '0;
         state_q   <= '0;
         round_q   <= '0;
         busy_q    <= 1'b0;
         restart_q <= 1'b1;
         // NOTE: the round-key array is reset because it is a visible output
         // that must read zero during reset, not just internal storage.
         for (int i = 0; i < 15; i++) begin
            rk_q[i] <= '0;
         end
      end else if (capture) begin
         pt_q      <= plaintext;
         key_q     <= initial_key;
         state_q   <= plaintext ^ initial_key[255:128];
         rk_q[0]   <= initial_key[255:128];
         rk_q[1]   <= initial_key[127:0];
         for (int i = 2; i < 15; i++) begin
            rk_q[i] <= '0;
         end
         round_q   <= 4'd1;
         busy_q    <= 1'b1;
         restart_q <= 1'b0;
      end else if (busy_q) begin
         if (round_q >= 4'd2) begin
            rk_q[round_q] <= rk_next;
         end
         state_q <= round_out;
         if (round_q == 4'd14) begin
            busy_q <= 1'b0;
         end else begin
            round_q <= round_q + 4'd1;
         end
      end
   end

   assign ciphertext = state_q;

   // Flatten the round keys, rk0 in the most significant slice.
   always_comb begin
      key_chain = '0;
      for (int i = 0; i < 15; i++) begin
         key_chain[1919 - 128*i -: 128] = rk_q[i];
      end
   end

endmodule

// File: tb/tb_aes256_encryption.sv
// Self-checking bench for aes256_encryption using published AES-256 vectors.
module tb_aes256_encryption;

   logic          clk_i;
   logic          reset_i;
   logic [127:0]  plaintext;
   logic [255:0]  initial_key;
   logic [127:0]  ciphertext;
   logic [1919:0] key_chain;

   int checks   = 0;
   int failures = 0;

   logic [127:0] sb_q [$];

   typedef struct {
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] RK2_C3  = 128'ha573c29fa176c498a97fce93a572c09c;
   localparam logic [127:0] RK14_C3 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
   localparam logic [255:0] KEY_SP  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

   vec_t vecs [4];

   aes256_encryption dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .plaintext   (plaintext),
      .initial_key (initial_key),
      .ciphertext  (ciphertext),
      .key_chain   (key_chain)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rk(input int i);
      return key_chain[1919 - 128*i -: 128];
   endfunction

   // Drive inputs only (used for runs that will be aborted).
   task automatic drive(input logic [255:0] key, input logic [127:0] pt);
      initial_key = key;
      plaintext   = pt;
   endtask

   // Drive inputs and record the expected result in the scoreboard.
   task automatic launch(input logic [255:0] key, input logic [127:0] pt, input logic [127:0] ct);
      drive(key, pt);
      sb_q.push_back(ct);
   endtask

   // Wait the full latency from a launch and compare against the scoreboard.
   task automatic retire(input string name);
      logic [127:0] exp;
      repeat (15) @(posedge clk_i);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=empty_scoreboard required=entry", name);
      end else begin
         exp = sb_q.pop_front();
         check(name, ciphertext, exp);
      end
   endtask

   initial begin
      vecs[0] = '{key: KEY_SP, pt: 128'h6bc1bee22e409f96e93d7e117393172a, ct: 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};
      vecs[1] = '{key: KEY_SP, pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51, ct: 128'h591ccb10d410ed26dc5ba74a31362870};
      vecs[2] = '{key: KEY_SP, pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef, ct: 128'hb6ed21b99ca6f4f9f153e7b1beafed1d};
      vecs[3] = '{key: KEY_SP, pt: 128'hf69f2445df4f9b17ad2b417be66c3710, ct: 128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

      // Reset values with C.3 inputs already applied.
      reset_i = 1'b0;
      drive(KEY_C3, PT_C3);
      #12;
      check("reset_ciphertext", ciphertext, 128'h0);
      check("reset_rk0", rk(0), 128'h0);
      check("reset_rk14", rk(14), 128'h0);

      // FIPS-197 C.3 from reset release.
      @(negedge clk_i);
      reset_i = 1'b1;
      sb_q.push_back(CT_C3);
      retire("c3_ciphertext");
      check("c3_rk0", rk(0), KEY_C3[255:128]);
      check("c3_rk1", rk(1), KEY_C3[127:0]);
      check("c3_rk2", rk(2), RK2_C3);
      check("c3_rk14", rk(14), RK14_C3);

      // Hold inputs 100 cycles: nothing may change.
      repeat (100) @(posedge clk_i);
      #1;
      check("stable_ciphertext", ciphertext, CT_C3);
      check("stable_rk2", rk(2), RK2_C3);
      check("stable_rk14", rk(14), RK14_C3);

      // SP800-38A ECB vectors: key change, then plaintext-only changes.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         launch(vecs[i].key, vecs[i].pt, vecs[i].ct);
         retire($sformatf("sp800_block%0d", i));
         check($sformatf("sp800_block%0d_rk0", i), rk(0), KEY_SP[255:128]);
      end

      // Switch from C.3 to SP800-38A block 0 at round 7.
      @(negedge clk_i);
      drive(KEY_C3, PT_C3);
      repeat (7) @(posedge clk_i);
      @(negedge clk_i);
      launch(vecs[0].key, vecs[0].pt, vecs[0].ct);
      retire("midrun_ciphertext");
      check("midrun_rk0", rk(0), KEY_SP[255:128]);
      check("midrun_rk1", rk(1), KEY_SP[127:0]);

      // Reset asserted at round 5 clears everything immediately.
      @(negedge clk_i);
      drive(vecs[1].key, vecs[1].pt);
      repeat (5) @(posedge clk_i);
      #2;
      reset_i = 1'b0;
      #1;
      check("midreset_ciphertext", ciphertext, 128'h0);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("midreset_rk%0d", i), rk(i), 128'h0);
      end

      // All-zero key and block after release.
      drive(256'h0, 128'h0);
      @(negedge clk_i);
      reset_i = 1'b1;
      sb_q.push_back(CT_ZERO);
      retire("zero_ciphertext");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes256_encryption.md
# aes256_encryption

Iterative AES-256 encryption core: encrypts one 128-bit block under a 256-bit key and exposes both the ciphertext and the full 15-entry round-key schedule. It completes one round per clock and restarts automatically whenever its inputs change. It has no handshake of its own. It sits inside the BSG-handshaked encrypt wrapper, which holds the inputs stable and waits 15 clock edges before sampling the outputs.

## Interface
- No parameters.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `plaintext`  in  128  block to encrypt; byte 0 is in bits [127:120] (FIPS-197 order).
- `initial_key`  in  256  AES-256 key; bits [255:128] are round key 0 and bits [127:0] are round key 1.
- `ciphertext`  out  128  AES state register; holds the ciphertext once the computation completes.
- `key_chain`  out  1920  round keys rk0..rk14; rk0 at [1919:1792] and rk_i at [1919-128i -: 128].

## Operation
- Registers:
  - `pt_q` (128) and `key_q` (256): captured copies of the inputs.
  - `state_q` (128): the AES state; drives `ciphertext`.
  - `rk_q` (15×128): the round keys; drives `key_chain`.
  - `round_q` (4 bits, 0..14).
  - `busy_q`.
  - `restart_q`: set by reset.
- Capture happens on any edge where `restart_q` is set, or where `plaintext != pt_q`, or where `initial_key != key_q`. On a capture edge:
  - `pt_q` and `key_q` load the inputs.
  - `state_q` loads `plaintext ^ initial_key[255:128]`.
  - rk0 and rk1 load from `initial_key`; rk2..rk14 clear to 0.
  - `round_q` loads 1, `busy_q` sets and `restart_q` clears.
- Capture has priority over round processing: a change to either input in mid-computation aborts the computation and restarts it.
- Round edge r (`busy_q` set, no capture, r = `round_q`, 1..14):
  - If r ≥ 2, compute rk_r from rk_{r-2} and rk_{r-1} (described below) and store it.
  - For r = 1..13: `state_q` ← MixColumns(ShiftRows(SubBytes(state))) ^ rk_r.
  - For r = 14 the MixColumns step is omitted.
  - `round_q` increments. After r = 14, `busy_q` clears and all registers hold until the next capture.
- rk_r generation: let t = last 32-bit word of rk_{r-1}.
  - r even: t = SubWord(RotWord(t)) ^ {Rcon[r/2], 24'h0}, with Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
  - r odd: t = SubWord(t).
  - Then w0 = rk_{r-2}.w0 ^ t, and each following word is w_k = rk_{r-2}.w_k ^ w_{k-1}.
- The round datapath combinationally uses the rk_r value being computed on the same edge.
- MixColumns is over GF(2^8) with polynomial 0x11B. The S-box is the standard FIPS-197 table.

## Timing
- Reset values: `ciphertext` = 0, `key_chain` = 0, `round_q` = 0, `busy_q` = 0, `restart_q` = 1. The first edge after reset is released is always a capture edge.
- Latency: if the capture happens at edge 0, the final ciphertext and rk14 are registered at edge 14.
  - Inputs that change before edge N are captured at edge N. Outputs are final after edge N+14, which is within the wrapper's 15-edge wait.
- Outputs between capture and completion show intermediate values. Consumers must wait the full latency before reading.
- Inputs held stable after completion: outputs stay constant indefinitely and no recomputation occurs.
- Reset asserted in mid-computation: all outputs clear immediately (asynchronous), and a capture follows release.

## Structure
- A shared package `aes_pkg` holds:
  - the S-box constant array;
  - the Rcon constants;
  - functions `sub_word`, `rot_word`, `xtime`, `mix_columns`, `shift_rows` and `sub_bytes`.
- One sub-module, `aes_key_step`, is combinational: it takes rk_{r-2}, rk_{r-1} and r, and returns rk_r.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: key = 000102…1f, plaintext = 00112233445566778899aabbccddeeff, held from reset release.
  - After 15 edges: `ciphertext` = 8ea2b7ca516745bfeafc49904b496089.
  - Round keys: rk0 = 000102…0f, rk1 = 101112…1f, rk2 = a573c29fa176c498a97fce93a572c09c, rk14 = 24fc79ccbf0979e9371ac23c6d68de36.
- SP800-38A vector:
  - Stimulus: key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, plaintext = 6bc1bee22e409f96e93d7e117393172a.
  - Required: `ciphertext` = f3eed1bdb5d2a03c064b5a7e3db181f8 exactly 15 edges after the input change.
- Mid-run change: switch from the C.3 vector to the SP800-38A vector at round 7. Required: SP800-38A result 15 edges after the switch, with no leftover C.3 values.
- Stability: hold the inputs for 100 cycles after completion. Required: `ciphertext` and `key_chain` unchanged.
- Reset:
  - Assert `reset_i` low at round 5. Required: outputs read 0 at once.
  - With all-zero inputs, release reset. Required: `ciphertext` = dc95c078a2408989ad48a21492842087 (AES-256 of zero block under zero key) after 15 edges.
